// File: rtl/mac_accumulator_4x3.sv
// mac_accumulator_4x3: valid/ready accumulate stage behind the 4x3 multiplier.
// Sums a programmed number of 7-bit products into an ACC_W-bit accumulator and
// presents the result with a sticky overflow flag.
// Optional build macro MAC_ACC_SAT_EN: saturate the accumulator on overflow
// instead of wrapping modulo 2^ACC_W.
module mac_accumulator_4x3 #(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [6:0]       p,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_d;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_q_d;
    logic [ACC_W-1:0]   acc_out_d;
    logic               out_valid_d;
    logic               ovf_d;
    logic               busy_d;

    logic               beat;
    logic               last_beat;
    logic [LEN_W-1:0]   cnt_inc;
    logic [SUM_W-1:0]   sum_w;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;

    // Input port is open exactly while a run is in progress
    assign p_ready   = (state == S_RUN);
    assign beat      = p_valid & p_ready;
    assign cnt_inc   = cnt + LEN_W'(1);
    assign last_beat = (cnt_inc == len_q);

    // Widened add: the extra top bit is the carry out of the accumulator
    assign sum_w = {1'b0, acc} + SUM_W'(p);
    assign carry = sum_w[ACC_W];

`ifdef MAC_ACC_SAT_EN
    // Clamp at full scale; once clamped every later add carries again, so it stays put
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    // Wrap modulo 2^ACC_W
    assign acc_next = sum_w[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (beat && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        acc_d       = acc;
        cnt_d       = cnt;
        len_q_d     = len_q;
        acc_out_d   = acc_out;
        out_valid_d = out_valid;
        ovf_d       = ovf;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        len_q_d = len;
                        cnt_d   = '0;
                    end else begin
                        acc_out_d   = '0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (beat) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    ovf_d = ovf | carry;
                    if (last_beat) begin
                        acc_out_d   = acc_next;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            acc       <= acc_d;
            cnt       <= cnt_d;
            len_q     <= len_q_d;
            acc_out   <= acc_out_d;
            out_valid <= out_valid_d;
            ovf       <= ovf_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4x3.sv
// Bench for mac_accumulator_4x3: directed runs with a cycle-level expectation
// built from arithmetic on the driven products, checked every falling edge.
module tb_mac_accumulator_4x3;

    localparam int unsigned ACC_W = 10;
    localparam int unsigned LEN_W = 4;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int ACC_MAX = ACC_MOD - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [6:0]       p;
    logic             p_valid;
    logic             p_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic             busy;

    mac_accumulator_4x3 #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .p         (p),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Expected output values for the current cycle
    logic exp_valid = 1'b0;
    logic exp_busy  = 1'b0;
    logic exp_pr    = 1'b0;
    logic exp_ovf   = 1'b0;
    int   exp_acc   = 0;

    int pv [16];

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle compare against the expectation
    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("busy", int'(busy), int'(exp_busy));
        chk("p_ready", int'(p_ready), int'(exp_pr));
        chk("ovf", int'(ovf), int'(exp_ovf));
        chk("acc_out", int'(acc_out), exp_acc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_result(input int total);
`ifdef MAC_ACC_SAT_EN
        return (total > ACC_MAX) ? ACC_MAX : total;
`else
        return total % ACC_MOD;
`endif
    endfunction

    // Start a run of n beats; pat gives p_valid per cycle (LSB first)
    task automatic run_to_done(input int n, input logic [31:0] pat);
        int beats;
        int total;
        beats = 0;
        total = 0;
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start   = 1'b0;
        exp_ovf = 1'b0;
        exp_busy = 1'b1;
        if (n == 0) begin
            exp_valid = 1'b1;
            exp_pr    = 1'b0;
            exp_acc   = 0;
            return;
        end
        exp_pr = 1'b1;
        for (int i = 0; i < 32 && beats < n; i++) begin
            p       = 7'(pv[beats]);
            p_valid = pat[i];
            tick();
            if (pat[i]) begin
                total += pv[beats];
                beats++;
                exp_ovf = (total > ACC_MAX);
                if (beats == n) begin
                    exp_valid = 1'b1;
                    exp_pr    = 1'b0;
                    exp_acc   = model_result(total);
                end
            end
        end
        p_valid = 1'b0;
        p       = '0;
    endtask

    // Hold out_ready low for some cycles, optionally poking start, then handshake
    task automatic drain(input int hold, input bit poke);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = poke && (i == 1);
            len   = LEN_W'(3);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start     = poke;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_pr    = 1'b0;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        p         = '0;
        p_valid   = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_acc_out", int'(acc_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic run
        pv[0] = 105; pv[1] = 1; pv[2] = 0;
        run_to_done(3, 32'hFFFF_FFFF);
        chk("basic_literal_acc", int'(acc_out), 106);
        chk("basic_literal_ovf", int'(ovf), 0);
        drain(0, 1'b0);

        // Input stalls
        for (int i = 0; i < 4; i++) pv[i] = 7;
        run_to_done(4, 32'b1011001);
        chk("stall_literal_acc", int'(acc_out), 28);
        drain(1, 1'b0);

        // Overflow
        for (int i = 0; i < 10; i++) pv[i] = 105;
        run_to_done(10, 32'hFFFF_FFFF);
`ifdef MAC_ACC_SAT_EN
        chk("ovf_literal_acc", int'(acc_out), 1023);
`else
        chk("ovf_literal_acc", int'(acc_out), 26);
`endif
        chk("ovf_literal_flag", int'(ovf), 1);
        drain(2, 1'b0);

        // Zero length, backpressure, ignored start in DONE and in the handshake
        run_to_done(0, 32'h0);
        chk("zero_literal_acc", int'(acc_out), 0);
        drain(5, 1'b1);

        // Reset mid-run
        for (int i = 0; i < 5; i++) pv[i] = 3;
        start = 1'b1;
        len   = LEN_W'(5);
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_pr   = 1'b1;
        p        = 7'd3;
        p_valid  = 1'b1;
        tick();
        tick();
        p_valid = 1'b0;
        #2;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_pr    = 1'b0;
        exp_ovf   = 1'b0;
        exp_acc   = 0;
        rst_n = 1'b0;
        #1;
        chk("async_p_ready", int'(p_ready), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_acc_out", int'(acc_out), 0);
        chk("async_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        pv[0] = 127;
        run_to_done(1, 32'h1);
        chk("post_reset_literal_acc", int'(acc_out), 127);
        drain(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case the sequence stalls
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/mac_accumulator_4x3.md
Name: mac_accumulator_4x3

Overview:
- Sequential accumulate stage directly downstream of the 4x3 array multiplier.
- Consumes the 7-bit unsigned product p[6:0] through a valid/ready handshake and sums a programmed number of products into an ACC_W-bit accumulator.
- Presents the sum on a valid/ready output port with a sticky overflow flag.
- Together with the multiplier it forms a small dot-product/MAC datapath.

Parameters:
- ACC_W, 10, accumulator and result width in bits (must be >= 7).
- LEN_W, 4, width of the beat-count field; max run length 2^LEN_W-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE.
- len  input  LEN_W  number of products in the run; sampled on the accepted start.
- p  input  7  unsigned product from the multiplier stage.
- p_valid  input  1  p is valid this cycle.
- p_ready  output  1  block accepts p this cycle.
- acc_out  output  ACC_W  accumulated result.
- out_valid  output  1  acc_out/ovf valid.
- out_ready  input  1  downstream accepts the result.
- ovf  output  1  sticky overflow for the current result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0, cnt=0, len_q=0; p_ready=0, out_valid=0, acc_out=0, ovf=0, busy=0. Reset applied mid-run aborts the run; no partial result is emitted.
- States: IDLE, RUN, DONE. Outputs are registered, except that p_ready is decoded from state (p_ready=1 iff state==RUN).
- IDLE:
  - start=1 and len!=0: len_q<=len, acc<=0, cnt<=0, ovf<=0, go to RUN.
  - start=1 and len==0: acc<=0, ovf<=0, go to DONE. out_valid rises the next cycle with acc_out=0.
  - start=0: stay in IDLE.
- RUN:
  - Beat = p_valid & p_ready.
  - On a beat: acc<=acc+p, computed ACC_W+1 bits wide. The carry out of bit ACC_W-1 sets ovf (sticky). Non-SAT build: the stored sum wraps mod 2^ACC_W.
  - On a beat: cnt<=cnt+1. If cnt+1==len_q, go to DONE.
  - No beat: hold all state.
  - start is ignored while in RUN.
- DONE:
  - out_valid=1; acc_out=acc; ovf reflects the run.
  - Output stays stable until out_valid & out_ready. On that handshake, out_valid<=0 and the state goes to IDLE the next cycle.
  - start is ignored while in DONE, even in the handshake cycle.
  - p_ready=0.
- Latency: out_valid asserts on the first clock edge after the last accepted beat. With p_valid held high, a run of N beats takes 1 (start) + N + 1 cycles to reach out_valid.
- Throughput: one beat per cycle; back-to-back runs need one IDLE cycle between them.
- acc_out holds its last value after the handshake until the next run reaches DONE.
- busy = (state!=IDLE).

Optional Feature:
- Macro MAC_ACC_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the run; ovf is still set.
- Undefined: wrap-around arithmetic mod 2^ACC_W; ovf set on the first carry out.
- Handshake and timing are identical in both builds.

Test Plan:
- Basic run: start with len=3; beats p=105, 1, 0 with p_valid held high -> out_valid one cycle after the 3rd beat, acc_out=106, ovf=0; out_ready=1 -> IDLE next cycle.
- Input stalls: len=4, p=7 each, p_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats counted, acc_out=28; p_ready=0 in IDLE and DONE.
- Overflow, ACC_W=10: len=10, p=105 each.
  - Without macro: acc_out=26 (1050 mod 1024), ovf=1.
  - With MAC_ACC_SAT_EN: acc_out=1023, ovf=1.
- Zero length and output backpressure: start with len=0 -> out_valid next cycle, acc_out=0. Hold out_ready=0 for 5 cycles -> out_valid and acc_out stable; a start pulse during DONE is ignored.
- Reset mid-run: len=5, 2 beats accepted, then rst_n=0 asynchronously between clock edges -> all outputs go to 0 immediately. After release, start with len=1 and p=127 -> acc_out=127 (no residue from the aborted run).
